delay_pulse_gen: RTL and testbench
==================================

Name: delay_pulse_gen

Overview:
Stimulus generator for the delay-measurement path. On a `go` request it emits a start pulse, then an end pulse a programmed number of clock cycles later. It repeats this for a programmed number of shots, with a fixed idle gap between shots. Its outputs drive the delay-measurement block's `t_start` (rising edge active, idle low) and `t_end` (falling edge active, idle high) inputs, giving a known-delay source for calibration and self-test.

Parameters:
- W, 16, width of the `delay` input and delay arithmetic.
- PW, 4, active width in clock cycles of both `t_start` (high) and `t_end` (low); legal range 1..255.
- GAP, 16, idle cycles between the end of one shot and the start of the next; legal range 1..65535.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- go  in  1  start request; sampled only in IDLE.
- abort  in  1  synchronous abort; highest priority after reset.
- delay  in  W  cycles from `t_start` rise to `t_end` fall; latched on accepted `go`.
- count  in  8  number of shots; latched on accepted `go`; 0 is treated as 1.
- t_start  out  1  start pulse, active high, registered.
- t_end  out  1  end pulse, active low, registered.
- busy  out  1  high from the cycle after `go` is accepted until return to IDLE.
- done  out  1  one-cycle pulse on normal completion of the last shot.
- shot_idx  out  8  zero-based index of the current shot; holds its last value after completion.

Behaviour:
- Reset (asynchronous assert, deassert synchronised to `clk` edge): state IDLE, `t_start`=0, `t_end`=1, `busy`=0, `done`=0, `shot_idx`=0, internal counters 0.
- FSM states: IDLE, SHOT, GAPW.
- IDLE → SHOT when `go`=1 and `abort`=0.
  - Latch D = max(`delay`,1) and N = max(`count`,1).
  - Clear `shot_idx` and the cycle counter c.
  - `go` is ignored in every non-IDLE state; a level-held `go` re-triggers only after returning to IDLE.
- SHOT uses cycle counter c, width W+1 so that D+PW cannot wrap. c=0 is the first clock edge at which `t_start`=1, i.e. the edge after the accepting edge.
  - `t_start`=1 for c in [0, PW-1].
  - `t_end`=0 for c in [D, D+PW-1].
  - The two windows may overlap (D < PW); each output follows its own window independently.
  - Exit when c = max(PW, D+PW) - 1 = D+PW-1. Outputs return to idle levels on the next edge.
- SHOT → GAPW: GAP-cycle countdown with both outputs idle.
  - At the end of GAPW, if `shot_idx` = N-1 go to IDLE with `done`=1 for exactly one cycle and `busy`=0 on the same edge.
  - Otherwise increment `shot_idx`, clear c, and enter SHOT.
- Measured delay between the sampled `t_start` rise and the sampled `t_end` fall is exactly D edges. Shot period is D+PW+GAP cycles.
- Abort: `abort`=1 in any state → IDLE on the next edge.
  - `t_start`=0, `t_end`=1, `busy`=0, no `done`.
  - `shot_idx` holds its value.
  - `abort` and `go` together in IDLE: stay IDLE.
- `delay` and `count` changes while busy have no effect until the next accepted `go`.
- `delay`=2^W-1 with PW=255: c reaches 2^W+253 without overflow.

Test Plan:
- Reset, then `go` with `delay`=10, `count`=1, PW=4, GAP=16 → `t_start` high 4 cycles from cycle 1; `t_end` low 4 cycles starting 10 cycles after the `t_start` rise; `done` pulse 16 gap cycles after `t_end` returns high; `busy` covers exactly that span.
- `delay`=0 and `delay`=2 with PW=4 → `delay`=0 behaves as D=1; for D=2, `t_start` and `t_end` are both active in cycles 2–3; the falling edge of `t_end` is still at offset D.
- `count`=3, `delay`=100 → three shots of period 120 cycles; `shot_idx` 0,1,2; a single `done`; `count`=0 gives exactly one shot.
- `go` pulsed mid-shot with `delay` changed to 50 → ignored; all shots keep D=100; a fresh `go` after `done` uses 50.
- `abort` asserted while `t_end`=0 in shot 1 of 3 → next edge `t_end`=1, `t_start`=0, `busy`=0, no `done`, `shot_idx`=1; `rst_n` pulsed low mid-shot → outputs go to reset values immediately, without waiting for a clock edge.
- `delay`=16'hFFFF, PW=255 → `t_end` fall occurs exactly 65535 cycles after the `t_start` rise; no early wrap.

Source files
------------

// File: rtl/delay_pulse_gen.sv
// Known-delay stimulus source: per shot, a PW-wide high pulse on t_start, then a
// PW-wide low pulse on t_end whose falling edge lands D edges after t_start rises.
module delay_pulse_gen #(
    parameter int W   = 16,
    parameter int PW  = 4,    // 1..255
    parameter int GAP = 16    // 1..65535
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic         abort,
    input  logic [W-1:0] delay,
    input  logic [7:0]   count,
    output logic         t_start,
    output logic         t_end,
    output logic         busy,
    output logic         done,
    output logic [7:0]   shot_idx,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOT = 2'd1,
        S_GAPW = 2'd2
    } state_t;

    // One extra bit on the shot counter so D+PW-1 never wraps.
    localparam int CW = W + 1;
    localparam int GW = 16;
    localparam logic [CW-1:0] PW_C     = CW'(PW);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [GW-1:0] g_q, g_d;
    logic [W-1:0]  d_q, d_d;
    logic [7:0]    n_q, n_d;
    logic [7:0]    idx_q, idx_d;
    logic          t_start_q, t_start_d;
    logic          t_end_q, t_end_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [CW-1:0] d_ext;
    logic [CW-1:0] c_last;
    logic          start_win;
    logic          end_win;
    logic          shot_last;
    logic          gap_last;
    logic          final_shot;

    assign d_ext      = {1'b0, d_q};
    assign c_last     = d_ext + PW_C - CW'(1);
    assign start_win  = (c_q < PW_C);
    assign end_win    = (c_q >= d_ext) && (c_q <= c_last);
    assign shot_last  = (c_q == c_last);
    assign gap_last   = (g_q == '0);
    assign final_shot = (idx_q == (n_q - 8'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            c_q       <= '0;
            g_q       <= '0;
            d_q       <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            t_start_q <= 1'b0;
            t_end_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            g_q       <= g_d;
            d_q       <= d_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            t_start_q <= t_start_d;
            t_end_q   <= t_end_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (go) state_d = S_SHOT;
                S_SHOT: if (shot_last) state_d = S_GAPW;
                S_GAPW: begin
                    if (gap_last) state_d = final_shot ? S_IDLE : S_SHOT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered: each value computed here appears after the edge
    // that evaluates counter value c_q, so t_start rises on the c=0 edge.
    always_comb begin
        c_d       = c_q;
        g_d       = g_q;
        d_d       = d_q;
        n_d       = n_q;
        idx_d     = idx_q;
        t_start_d = 1'b0;
        t_end_d   = 1'b1;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (abort) begin
            busy_d = 1'b0;
            c_d    = '0;
            g_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        d_d    = (delay == '0) ? W'(1) : delay;
                        n_d    = (count == 8'd0) ? 8'd1 : count;
                        idx_d  = 8'd0;
                        c_d    = '0;
                        busy_d = 1'b1;
                    end
                end
                S_SHOT: begin
                    t_start_d = start_win;
                    t_end_d   = ~end_win;
                    if (shot_last) begin
                        c_d = '0;
                        g_d = GAP_LAST;
                    end else begin
                        c_d = c_q + CW'(1);
                    end
                end
                S_GAPW: begin
                    if (gap_last) begin
                        if (final_shot) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 8'd1;
                            c_d   = '0;
                        end
                    end else begin
                        g_d = g_q - GW'(1);
                    end
                end
                default: begin
                    busy_d = 1'b0;
                end
            endcase
        end
    end

    assign t_start   = t_start_q;
    assign t_end     = t_end_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign shot_idx  = idx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_delay_pulse_gen.sv
// Event-timestamp scoreboard bench for delay_pulse_gen: every expected output
// edge is pushed with its absolute clock-edge number when go is driven.
module tb_delay_pulse_gen;

    localparam int PW_S  = 4;
    localparam int GAP_S = 16;
    localparam int PW_B  = 255;
    localparam int GAP_B = 16;
    localparam logic [43:0] NONE = '1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic        sel_big = 1'b0;
    logic [15:0] delay_i = '0;
    logic [7:0]  count_i = '0;
    logic        go_s, go_b;

    logic       s_ts, s_te, s_busy, s_done;
    logic [7:0] s_idx;
    logic [1:0] s_state;
    logic       b_ts, b_te, b_busy, b_done;
    logic [7:0] b_idx;
    logic [1:0] b_state;
    logic       m_ts, m_te, m_busy, m_done;
    logic [7:0] m_idx;
    logic [1:0] m_state;

    logic [43:0] exp_q[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic        mon_en = 1'b0;
    logic        p_ts = 1'b0, p_te = 1'b1, p_busy = 1'b0, p_done = 1'b0;

    assign go_s = go & ~sel_big;
    assign go_b = go & sel_big;

    assign m_ts    = sel_big ? b_ts    : s_ts;
    assign m_te    = sel_big ? b_te    : s_te;
    assign m_busy  = sel_big ? b_busy  : s_busy;
    assign m_done  = sel_big ? b_done  : s_done;
    assign m_idx   = sel_big ? b_idx   : s_idx;
    assign m_state = sel_big ? b_state : s_state;

    delay_pulse_gen #(.W(16), .PW(PW_S), .GAP(GAP_S)) u_dut (
        .clk(clk), .rst_n(rst_n), .go(go_s), .abort(abort),
        .delay(delay_i), .count(count_i),
        .t_start(s_ts), .t_end(s_te), .busy(s_busy), .done(s_done),
        .shot_idx(s_idx), .dbg_state(s_state)
    );

    delay_pulse_gen #(.W(16), .PW(PW_B), .GAP(GAP_B)) u_big (
        .clk(clk), .rst_n(rst_n), .go(go_b), .abort(abort),
        .delay(delay_i), .count(count_i),
        .t_start(b_ts), .t_end(b_te), .busy(b_busy), .done(b_done),
        .shot_idx(b_idx), .dbg_state(b_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [43:0] obs, input logic [43:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic string kind_name(input int k);
        case (k)
            0: return "busy_rise";
            1: return "start_rise";
            2: return "start_fall";
            3: return "end_fall";
            4: return "end_rise";
            5: return "done_rise";
            6: return "busy_fall";
            default: return "done_fall";
        endcase
    endfunction

    function automatic void push(input int c, input int k, input int dat);
        exp_q.push_back({32'(c), 4'(k), 8'(dat)});
    endfunction

    // Entry layout: [43:12] edge number, [11:8] event kind, [7:0] shot_idx where relevant.
    always @(negedge clk) begin
        logic [7:0]  ev;
        logic [43:0] head;
        logic [43:0] obs;
        if (mon_en) begin
            while (exp_q.size() > 0) begin
                head = exp_q[0];
                if (head[43:12] >= 32'(cyc)) break;
                check("missed_event", NONE, head);
                void'(exp_q.pop_front());
            end
            ev[0] =  m_busy & ~p_busy;
            ev[1] =  m_ts   & ~p_ts;
            ev[2] = ~m_ts   &  p_ts;
            ev[3] = ~m_te   &  p_te;
            ev[4] =  m_te   & ~p_te;
            ev[5] =  m_done & ~p_done;
            ev[6] = ~m_busy &  p_busy;
            ev[7] = ~m_done &  p_done;
            for (int k = 0; k < 8; k++) begin
                if (ev[k]) begin
                    obs = {32'(cyc), 4'(k), (k == 1 || k == 5) ? m_idx : 8'd0};
                    if (exp_q.size() == 0) check(kind_name(k), obs, NONE);
                    else check(kind_name(k), obs, exp_q.pop_front());
                end
            end
        end
        p_ts   = m_ts;
        p_te   = m_te;
        p_busy = m_busy;
        p_done = m_done;
    end

    // ---------------- drivers ----------------
    task automatic send_go(input int dly, input int cnt);
        int d, n, pw, gp, p, a, b;
        @(negedge clk);
        #1;
        d  = (dly == 0) ? 1 : dly;
        n  = (cnt == 0) ? 1 : cnt;
        pw = sel_big ? PW_B : PW_S;
        gp = sel_big ? GAP_B : GAP_S;
        p  = d + pw + gp;
        a  = cyc + 1;
        delay_i = 16'(dly);
        count_i = 8'(cnt);
        go = 1'b1;
        push(a, 0, 0);
        for (int s = 0; s < n; s++) begin
            b = a + 1 + s * p;
            push(b, 1, s);
            push(b + pw, 2, 0);
            push(b + d, 3, 0);
            push(b + d + pw, 4, 0);
        end
        push(a + n * p, 5, n - 1);
        push(a + n * p, 6, 0);
        push(a + n * p + 1, 7, 0);
        exp_q.sort();
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (exp_q.size() > 0) begin
            check("timeout", 44'(exp_q.size()), 44'd0);
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a;
        repeat (3) @(negedge clk);
        check("rst_t_start", 44'(m_ts), 44'd0);
        check("rst_t_end", 44'(m_te), 44'd1);
        check("rst_busy", 44'(m_busy), 44'd0);
        check("rst_done", 44'(m_done), 44'd0);
        check("rst_shot_idx", 44'(m_idx), 44'd0);
        check("rst_state", 44'(m_state), 44'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 mon_en = 1'b1;

        send_go(10, 1);  wait_idle(200);
        send_go(0, 1);   wait_idle(200);
        send_go(2, 1);   wait_idle(200);
        send_go(100, 3); wait_idle(800);
        send_go(100, 0); wait_idle(300);

        // go mid-shot must be ignored; the new delay applies only to the next go
        send_go(100, 2);
        repeat (20) @(negedge clk);
        #1;
        go = 1'b1; delay_i = 16'd50; count_i = 8'd5;
        @(posedge clk);
        #1 go = 1'b0;
        wait_idle(600);
        send_go(50, 1);  wait_idle(300);

        // abort during the t_end pulse of shot 1 of 3
        send_go(100, 3);
        repeat (222) @(negedge clk);
        check("pre_abort_t_end", 44'(m_te), 44'd0);
        #1;
        exp_q.delete();
        a = cyc + 1;
        if (m_ts) push(a, 2, 0);
        if (!m_te) push(a, 4, 0);
        if (m_busy) push(a, 6, 0);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_t_start", 44'(m_ts), 44'd0);
        check("abort_t_end", 44'(m_te), 44'd1);
        check("abort_busy", 44'(m_busy), 44'd0);
        check("abort_done", 44'(m_done), 44'd0);
        check("abort_shot_idx", 44'(m_idx), 44'd1);
        check("abort_state", 44'(m_state), 44'd0);
        repeat (400) @(negedge clk);

        // go together with abort in IDLE stays idle
        #1;
        go = 1'b1; abort = 1'b1; delay_i = 16'd7; count_i = 8'd1;
        @(posedge clk);
        #1 go = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        check("go_abort_busy", 44'(m_busy), 44'd0);
        check("go_abort_state", 44'(m_state), 44'd0);

        // asynchronous reset mid-shot while t_start is high in shot 1
        send_go(10, 2);
        repeat (33) @(negedge clk);
        check("pre_rst_t_start", 44'(m_ts), 44'd1);
        check("pre_rst_shot_idx", 44'(m_idx), 44'd1);
        #1;
        mon_en = 1'b0;
        exp_q.delete();
        #1 rst_n = 1'b0;
        #1;
        check("arst_t_start", 44'(m_ts), 44'd0);
        check("arst_t_end", 44'(m_te), 44'd1);
        check("arst_busy", 44'(m_busy), 44'd0);
        check("arst_done", 44'(m_done), 44'd0);
        check("arst_shot_idx", 44'(m_idx), 44'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 mon_en = 1'b1;
        send_go(3, 1);   wait_idle(200);

        // widest delay with PW=255: t_end falls 65535 edges after t_start rises
        #1 sel_big = 1'b1;
        repeat (2) @(negedge clk);
        send_go(65535, 1);
        wait_idle(70000);

        check("sb_empty", 44'(exp_q.size()), 44'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
